// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART colour-command controller.
// Holds the error codes (receiver codes plus controller codes), the FSM state
// encodings, the frame header default, the RGB payload type and the frame
// checksum helper.
package uart_cmd_ctrl_pkg;

    localparam int unsigned WIDTH_DATABITS = 8;
    localparam int unsigned WIDTH_ERROR    = 3;
    localparam int unsigned WIDTH_STATE    = 3;
    localparam int unsigned WIDTH_STAT     = 16;

    // Error codes: receiver codes pass through unchanged, controller codes follow
    localparam logic [WIDTH_ERROR-1:0] NO_ERRORS         = 3'd0;
    localparam logic [WIDTH_ERROR-1:0] FAILED_PARITY_BIT = 3'd1;
    localparam logic [WIDTH_ERROR-1:0] FAILED_STOP_BIT   = 3'd2;
    localparam logic [WIDTH_ERROR-1:0] ERR_CHECKSUM      = 3'd3;
    localparam logic [WIDTH_ERROR-1:0] ERR_TIMEOUT       = 3'd4;

    // Frame sequencer states
    localparam logic [WIDTH_STATE-1:0] S_HDR = 3'd0;
    localparam logic [WIDTH_STATE-1:0] S_R   = 3'd1;
    localparam logic [WIDTH_STATE-1:0] S_G   = 3'd2;
    localparam logic [WIDTH_STATE-1:0] S_B   = 3'd3;
    localparam logic [WIDTH_STATE-1:0] S_CHK = 3'd4;

    localparam logic [WIDTH_DATABITS-1:0] HDR_BYTE_DEF = 8'hA5;

    // One colour command payload
    typedef struct packed {
        logic [WIDTH_DATABITS-1:0] r;
        logic [WIDTH_DATABITS-1:0] g;
        logic [WIDTH_DATABITS-1:0] b;
    } rgb_t;

    // Frame check byte: XOR of the three colour bytes
    function automatic logic [WIDTH_DATABITS-1:0] frame_chk(input rgb_t c);
        return c.r ^ c.g ^ c.b;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timer.sv
// Inter-byte timeout counter.
// Ports: clk, rst_n (async active-low), clr (clear, highest priority),
//        en (count enable), expired (counter has reached TIMEOUT_CYC).
// The counter saturates at TIMEOUT_CYC; expired is registered so it tracks
// the stored count exactly.
module uart_cmd_timer #(
    parameter int unsigned TIMEOUT_CYC = 10000,
    parameter int unsigned WIDTH_TMO   = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WIDTH_TMO-1:0] TMO_VAL = WIDTH_TMO'(TIMEOUT_CYC);

    logic [WIDTH_TMO-1:0] cnt_q, cnt_d;
    logic                 expired_q;

    // Next count: clear wins, otherwise count up to the limit and hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TMO_VAL)) begin
            cnt_d = cnt_q + WIDTH_TMO'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == TMO_VAL);
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART colour-command controller.
// Collects 5-byte frames (HDR,R,G,B,CHK) from the UART receiver, checks them,
// applies an inter-byte timeout, forwards receiver errors and emits one
// colour pulse per good frame. Also drives the receiver's parity/stop config,
// which only changes between frames.
// Ports:
//   clk, rst (async active-low)
//   cfg_parity, cfg_stop2         requested receiver configuration
//   rx_out, rx_ready_out          received byte and its ready level
//   rx_error, rx_ready_err        receiver error code and its ready level
//   paritybit, stopbit            configuration to the receiver
//   col_r/g/b, col_valid          last accepted colour and its 1-cycle pulse
//   err_code, err_valid           last error code and its 1-cycle pulse
// Build option UART_CMD_STATS_EN adds frame_cnt/err_cnt saturating counters.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter logic [WIDTH_DATABITS-1:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter int unsigned               TIMEOUT_CYC = 10000,
    parameter int unsigned               WIDTH_TMO   = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_parity,
    input  logic                      cfg_stop2,
    input  logic [WIDTH_DATABITS-1:0] rx_out,
    input  logic                      rx_ready_out,
    input  logic [WIDTH_ERROR-1:0]    rx_error,
    input  logic                      rx_ready_err,
    output logic                      paritybit,
    output logic                      stopbit,
    output logic [WIDTH_DATABITS-1:0] col_r,
    output logic [WIDTH_DATABITS-1:0] col_g,
    output logic [WIDTH_DATABITS-1:0] col_b,
    output logic                      col_valid,
    output logic [WIDTH_ERROR-1:0]    err_code,
    output logic                      err_valid
`ifdef UART_CMD_STATS_EN
    ,
    output logic [WIDTH_STAT-1:0]     frame_cnt,
    output logic [WIDTH_STAT-1:0]     err_cnt
`endif
);

    logic                   rdy_q, erdy_q;
    logic                   byte_ev, err_ev;
    logic [WIDTH_STATE-1:0] state_q, state_d;
    rgb_t                   stage_q, stage_d;
    rgb_t                   col_q, col_d;
    logic                   col_valid_q, col_valid_d;
    logic                   err_valid_q, err_valid_d;
    logic [WIDTH_ERROR-1:0] err_code_q, err_code_d;
    logic                   par_q, par_d;
    logic                   stop_q, stop_d;
    logic                   tmo_expired;
`ifdef UART_CMD_STATS_EN
    logic [WIDTH_STAT-1:0]  frame_cnt_q, frame_cnt_d;
    logic [WIDTH_STAT-1:0]  err_cnt_q, err_cnt_d;
`endif

    // Receiver ready inputs are levels; act only on their rising edges
    assign byte_ev = rx_ready_out & ~rdy_q;
    assign err_ev  = rx_ready_err & ~erdy_q;

    // Timer runs only while a frame is in progress
    uart_cmd_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .WIDTH_TMO   (WIDTH_TMO)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (byte_ev | (state_q == S_HDR)),
        .en      (state_q != S_HDR),
        .expired (tmo_expired)
    );

    // Next-state and output logic; priority: receiver error, byte, timeout
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        col_d       = col_q;
        col_valid_d = 1'b0;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        par_d       = par_q;
        stop_d      = stop_q;

        // Config is only taken between frames, when the receiver is quiet
        if ((state_q == S_HDR) && !rx_ready_out && !rx_ready_err) begin
            par_d  = cfg_parity;
            stop_d = cfg_stop2;
        end

        if (err_ev) begin
            err_code_d  = rx_error;
            err_valid_d = 1'b1;
            state_d     = S_HDR;
        end else if (byte_ev) begin
            case (state_q)
                S_HDR: begin
                    if (rx_out == HDR_BYTE) begin
                        state_d = S_R;
                    end
                end
                S_R: begin
                    stage_d.r = rx_out;
                    state_d   = S_G;
                end
                S_G: begin
                    stage_d.g = rx_out;
                    state_d   = S_B;
                end
                S_B: begin
                    stage_d.b = rx_out;
                    state_d   = S_CHK;
                end
                S_CHK: begin
                    state_d = S_HDR;
                    if (rx_out == frame_chk(stage_q)) begin
                        col_d       = stage_q;
                        col_valid_d = 1'b1;
                    end else begin
                        err_code_d  = ERR_CHECKSUM;
                        err_valid_d = 1'b1;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end else if (tmo_expired && (state_q != S_HDR)) begin
            err_code_d  = ERR_TIMEOUT;
            err_valid_d = 1'b1;
            state_d     = S_HDR;
        end
    end

`ifdef UART_CMD_STATS_EN
    // Saturating statistics, stepped with the pulse they count
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (col_valid_d && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + WIDTH_STAT'(1);
        end
        if (err_valid_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + WIDTH_STAT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q       <= 1'b0;
            erdy_q      <= 1'b0;
            state_q     <= S_HDR;
            stage_q     <= '0;
            col_q       <= '0;
            col_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= NO_ERRORS;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            rdy_q       <= rx_ready_out;
            erdy_q      <= rx_ready_err;
            state_q     <= state_d;
            stage_q     <= stage_d;
            col_q       <= col_d;
            col_valid_q <= col_valid_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
        end
    end

    assign paritybit = par_q;
    assign stopbit   = stop_q;
    assign col_r     = col_q.r;
    assign col_g     = col_q.g;
    assign col_b     = col_q.b;
    assign col_valid = col_valid_q;
    assign err_code  = err_code_q;
    assign err_valid = err_valid_q;

endmodule
